// File: rtl/div_sched_if.sv
// div_sched_if: bundles the requester, divider and result channels of div_sched.
// The slave modport is the scheduler's view; the master modport is the
// surrounding environment (requesters, divider unit, result consumer).
interface div_sched_if #(
    parameter int W_PD_UOPS = 6,
    parameter int W_PD_DATA = 32,
    parameter int W_PD_TAG  = 4
);
    // Requester 0
    logic                 CFI_PC_req0_vld;
    logic                 CFO_PC_req0_rdy;
    logic [W_PD_UOPS-1:0] DFI_PD_req0_uops;
    logic [W_PD_DATA-1:0] DFI_PD_req0_rs;
    logic [W_PD_DATA-1:0] DFI_PD_req0_rt;
    logic [W_PD_TAG-1:0]  DFI_PD_req0_tag;

    // Requester 1
    logic                 CFI_PC_req1_vld;
    logic                 CFO_PC_req1_rdy;
    logic [W_PD_UOPS-1:0] DFI_PD_req1_uops;
    logic [W_PD_DATA-1:0] DFI_PD_req1_rs;
    logic [W_PD_DATA-1:0] DFI_PD_req1_rt;
    logic [W_PD_TAG-1:0]  DFI_PD_req1_tag;

    // Divider control and operands
    logic                 CFO_PC_div_ena;
    logic                 CFO_PC_div_clear;
    logic [W_PD_UOPS-1:0] DFO_PD_div_uops;
    logic [W_PD_DATA-1:0] DFO_PD_div_rs;
    logic [W_PD_DATA-1:0] DFO_PD_div_rt;

    // Divider result
    logic [W_PD_DATA-1:0] DFI_PD_div_rs;
    logic                 DFI_PD_div_ofw;

    // Result channel
    logic                 CFO_PC_res_vld;
    logic                 CFI_PC_res_rdy;
    logic [W_PD_DATA-1:0] DFO_PD_res_data;
    logic                 DFO_PD_res_ofw;
    logic [W_PD_TAG-1:0]  DFO_PD_res_tag;
    logic                 DFO_PD_res_src;

    modport slave (
        input  CFI_PC_req0_vld, DFI_PD_req0_uops, DFI_PD_req0_rs, DFI_PD_req0_rt, DFI_PD_req0_tag,
        output CFO_PC_req0_rdy,
        input  CFI_PC_req1_vld, DFI_PD_req1_uops, DFI_PD_req1_rs, DFI_PD_req1_rt, DFI_PD_req1_tag,
        output CFO_PC_req1_rdy,
        output CFO_PC_div_ena, CFO_PC_div_clear, DFO_PD_div_uops, DFO_PD_div_rs, DFO_PD_div_rt,
        input  DFI_PD_div_rs, DFI_PD_div_ofw,
        output CFO_PC_res_vld, DFO_PD_res_data, DFO_PD_res_ofw, DFO_PD_res_tag, DFO_PD_res_src,
        input  CFI_PC_res_rdy
    );

    modport master (
        output CFI_PC_req0_vld, DFI_PD_req0_uops, DFI_PD_req0_rs, DFI_PD_req0_rt, DFI_PD_req0_tag,
        input  CFO_PC_req0_rdy,
        output CFI_PC_req1_vld, DFI_PD_req1_uops, DFI_PD_req1_rs, DFI_PD_req1_rt, DFI_PD_req1_tag,
        input  CFO_PC_req1_rdy,
        input  CFO_PC_div_ena, CFO_PC_div_clear, DFO_PD_div_uops, DFO_PD_div_rs, DFO_PD_div_rt,
        output DFI_PD_div_rs, DFI_PD_div_ofw,
        input  CFO_PC_res_vld, DFO_PD_res_data, DFO_PD_res_ofw, DFO_PD_res_tag, DFO_PD_res_src,
        output CFI_PC_res_rdy
    );
endinterface

// File: rtl/div_sched.sv
// div_sched: two-requester round-robin scheduler in front of a fixed-latency
// multi-cycle divider, with a one-entry result buffer.
// Optional feature macro: DIV_SCHED_DZ_FAST_EN -- when defined, divide/remainder
// ops with a zero divisor are answered directly from the scheduler without
// starting the divider.
module div_sched #(
    parameter int W_PD_UOPS = 6,
    parameter int W_PD_DATA = 32,
    parameter int W_PD_TAG  = 4,
    parameter int DIV_LAT   = 35
) (
    input  logic       clk,
    input  logic       CFI_PC_clear,
    div_sched_if.slave bus
);
    // Divider uop encodings for the signed ops.
    localparam logic [W_PD_UOPS-1:0] UOP_DIV = W_PD_UOPS'(20);
    localparam logic [W_PD_UOPS-1:0] UOP_REM = W_PD_UOPS'(22);

    localparam int              CNT_W    = $clog2(DIV_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t               state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 ptr_reg;
    logic [W_PD_TAG-1:0]  tag_reg;
    logic                 src_reg;
    logic [W_PD_UOPS-1:0] uops_reg;

    logic                 res_vld_reg;
    logic [W_PD_DATA-1:0] res_data_reg;
    logic                 res_ofw_reg;
    logic [W_PD_TAG-1:0]  res_tag_reg;
    logic                 res_src_reg;

    // Requester inputs gathered into arrays so the winner can be indexed.
    logic                 req_vld  [2];
    logic [W_PD_UOPS-1:0] req_uops [2];
    logic [W_PD_DATA-1:0] req_rs   [2];
    logic [W_PD_DATA-1:0] req_rt   [2];
    logic [W_PD_TAG-1:0]  req_tag  [2];

    assign req_vld[0]  = bus.CFI_PC_req0_vld;
    assign req_uops[0] = bus.DFI_PD_req0_uops;
    assign req_rs[0]   = bus.DFI_PD_req0_rs;
    assign req_rt[0]   = bus.DFI_PD_req0_rt;
    assign req_tag[0]  = bus.DFI_PD_req0_tag;
    assign req_vld[1]  = bus.CFI_PC_req1_vld;
    assign req_uops[1] = bus.DFI_PD_req1_uops;
    assign req_rs[1]   = bus.DFI_PD_req1_rs;
    assign req_rt[1]   = bus.DFI_PD_req1_rt;
    assign req_tag[1]  = bus.DFI_PD_req1_tag;

    // Round-robin pick: the pointer only decides a tie; a lone requester wins.
    logic any_vld;
    logic win_idx;
    assign any_vld = req_vld[0] | req_vld[1];
    assign win_idx = (req_vld[0] && req_vld[1]) ? ptr_reg : req_vld[1];

    logic [W_PD_UOPS-1:0] win_uops;
    logic [W_PD_DATA-1:0] win_rs;
    logic [W_PD_DATA-1:0] win_rt;
    logic [W_PD_TAG-1:0]  win_tag;
    assign win_uops = req_uops[win_idx];
    assign win_rs   = req_rs[win_idx];
    assign win_rt   = req_rt[win_idx];
    assign win_tag  = req_tag[win_idx];

    // The buffer can take a new result if it is empty or being read this cycle.
    logic buf_free;
    logic drain;
    assign buf_free = !res_vld_reg || bus.CFI_PC_res_rdy;
    assign drain    = res_vld_reg && bus.CFI_PC_res_rdy;

    // Zero-divisor shortcut: dz_hit marks an op answered without the divider.
    logic                 dz_hit;
    logic [W_PD_DATA-1:0] dz_data;
`ifdef DIV_SCHED_DZ_FAST_EN
    localparam logic [W_PD_UOPS-1:0] UOP_DIVU = W_PD_UOPS'(21);
    localparam logic [W_PD_UOPS-1:0] UOP_REMU = W_PD_UOPS'(23);

    logic win_is_quot;
    logic win_is_rem;
    assign win_is_quot = (win_uops == UOP_DIV) || (win_uops == UOP_DIVU);
    assign win_is_rem  = (win_uops == UOP_REM) || (win_uops == UOP_REMU);
    assign dz_hit      = (win_is_quot || win_is_rem) && (win_rt == '0);
    // Quotient of x/0 is all ones, remainder of x/0 is the dividend.
    assign dz_data     = win_is_quot ? '1 : win_rs;
`else
    assign dz_hit  = 1'b0;
    assign dz_data = '0;
`endif

    // A shortcut op additionally needs room in the result buffer this cycle.
    logic grant;
    logic div_ena;
    assign grant   = !CFI_PC_clear && (state_reg == IDLE) && any_vld && (!dz_hit || buf_free);
    assign div_ena = grant && !dz_hit;

    logic [1:0] req_rdy;
    for (genvar gi = 0; gi < 2; gi++) begin : g_rdy
        assign req_rdy[gi] = grant && (win_idx == 1'(gi));
    end

    // Divider operands: winner while starting, otherwise the favoured requester.
    logic op_sel;
    assign op_sel = div_ena ? win_idx : ptr_reg;

    // Overflow is only meaningful for signed ops; unsigned ones never report it.
    logic op_signed;
    assign op_signed = (uops_reg == UOP_DIV) || (uops_reg == UOP_REM);

    // Scheduler FSM, latency counter, round-robin pointer and result buffer.
    always_ff @(posedge clk) begin
        if (CFI_PC_clear) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            ptr_reg      <= 1'b0;
            tag_reg      <= '0;
            src_reg      <= 1'b0;
            uops_reg     <= '0;
            res_vld_reg  <= 1'b0;
            res_data_reg <= '0;
            res_ofw_reg  <= 1'b0;
            res_tag_reg  <= '0;
            res_src_reg  <= 1'b0;
        end else begin
            if (drain) begin
                res_vld_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (grant) begin
                        ptr_reg <= ~win_idx;
                        if (dz_hit) begin
                            res_vld_reg  <= 1'b1;
                            res_data_reg <= dz_data;
                            res_ofw_reg  <= 1'b0;
                            res_tag_reg  <= win_tag;
                            res_src_reg  <= win_idx;
                        end else begin
                            state_reg <= BUSY;
                            cnt_reg   <= CNT_W'(1);
                            tag_reg   <= win_tag;
                            src_reg   <= win_idx;
                            uops_reg  <= win_uops;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_reg == CNT_LAST) begin
                        if (buf_free) begin
                            res_vld_reg  <= 1'b1;
                            res_data_reg <= bus.DFI_PD_div_rs;
                            res_ofw_reg  <= bus.DFI_PD_div_ofw && op_signed;
                            res_tag_reg  <= tag_reg;
                            res_src_reg  <= src_reg;
                            state_reg    <= IDLE;
                            cnt_reg      <= '0;
                        end else begin
                            state_reg <= HOLD;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                HOLD: begin
                    if (buf_free) begin
                        res_vld_reg  <= 1'b1;
                        res_data_reg <= bus.DFI_PD_div_rs;
                        res_ofw_reg  <= bus.DFI_PD_div_ofw && op_signed;
                        res_tag_reg  <= tag_reg;
                        res_src_reg  <= src_reg;
                        state_reg    <= IDLE;
                        cnt_reg      <= '0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign bus.CFO_PC_req0_rdy  = req_rdy[0];
    assign bus.CFO_PC_req1_rdy  = req_rdy[1];
    assign bus.CFO_PC_div_ena   = div_ena;
    assign bus.CFO_PC_div_clear = CFI_PC_clear;
    assign bus.DFO_PD_div_uops  = req_uops[op_sel];
    assign bus.DFO_PD_div_rs    = req_rs[op_sel];
    assign bus.DFO_PD_div_rt    = req_rt[op_sel];
    assign bus.CFO_PC_res_vld   = res_vld_reg;
    assign bus.DFO_PD_res_data  = res_data_reg;
    assign bus.DFO_PD_res_ofw   = res_ofw_reg;
    assign bus.DFO_PD_res_tag   = res_tag_reg;
    assign bus.DFO_PD_res_src   = res_src_reg;
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: directed bench for div_sched with a behavioural fixed-latency divider.
module tb_div_sched;
    localparam int LAT = 35;
    localparam logic [5:0] U_DIV  = 6'd20;
    localparam logic [5:0] U_DIVU = 6'd21;
    localparam logic [5:0] U_REM  = 6'd22;
    localparam logic [5:0] U_REMU = 6'd23;

    logic clk = 1'b0;
    logic clear = 1'b1;
    always #5 clk = ~clk;

    div_sched_if #(.W_PD_UOPS(6), .W_PD_DATA(32), .W_PD_TAG(4)) bus ();

    div_sched #(.W_PD_UOPS(6), .W_PD_DATA(32), .W_PD_TAG(4), .DIV_LAT(LAT)) dut (
        .clk          (clk),
        .CFI_PC_clear (clear),
        .bus          (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference divider behaviour, including divide-by-zero and signed overflow.
    function automatic logic [32:0] div_model(input logic [5:0] u, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic        o;
        logic        ovf;
        q   = 32'h0;
        o   = 1'b0;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (u)
            U_DIVU: q = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            U_REMU: q = (b == 32'h0) ? a : a % b;
            U_DIV: begin
                if (b == 32'h0) q = 32'hFFFF_FFFF;
                else if (ovf) begin q = a; o = 1'b1; end
                else q = 32'($signed(a) / $signed(b));
            end
            U_REM: begin
                if (b == 32'h0) q = a;
                else if (ovf) begin q = 32'h0; o = 1'b1; end
                else q = 32'($signed(a) % $signed(b));
            end
            default: q = 32'h0;
        endcase
        return {o, q};
    endfunction

    // Divider stand-in: result valid LAT cycles after the enable cycle, held until the next enable.
    logic [5:0]  dcnt;
    logic [31:0] dq;
    logic        dofw;
    always @(posedge clk) begin
        if (bus.CFO_PC_div_clear) begin
            dcnt <= 6'd0;
        end else if (bus.CFO_PC_div_ena) begin
            dcnt <= 6'd1;
            {dofw, dq} <= div_model(bus.DFO_PD_div_uops, bus.DFO_PD_div_rs, bus.DFO_PD_div_rt);
        end else if (dcnt != 6'd0 && dcnt < 6'(LAT)) begin
            dcnt <= dcnt + 6'd1;
        end
    end
    assign bus.DFI_PD_div_rs  = (dcnt == 6'(LAT)) ? dq : 32'hDEAD_BEEF;
    assign bus.DFI_PD_div_ofw = (dcnt == 6'(LAT)) ? dofw : 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic v, input logic [5:0] u,
                           input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        if (idx == 0) begin
            bus.CFI_PC_req0_vld = v; bus.DFI_PD_req0_uops = u;
            bus.DFI_PD_req0_rs = a;  bus.DFI_PD_req0_rt = b; bus.DFI_PD_req0_tag = t;
        end else begin
            bus.CFI_PC_req1_vld = v; bus.DFI_PD_req1_uops = u;
            bus.DFI_PD_req1_rs = a;  bus.DFI_PD_req1_rt = b; bus.DFI_PD_req1_tag = t;
        end
    endtask

    // Waits for res_vld; drop selects requesters whose vld falls on the first cycle.
    task automatic wait_res(input logic [1:0] drop, output int n);
        n = 0;
        do begin
            @(negedge clk);
            if (n == 0) begin
                if (drop[0]) bus.CFI_PC_req0_vld = 1'b0;
                if (drop[1]) bus.CFI_PC_req1_vld = 1'b0;
            end
            #1;
            n++;
        end while (!bus.CFO_PC_res_vld && n < 100);
        $display("result: cycles=%0d src=%0d tag=%0d data=%h ofw=%0d", n,
                 bus.DFO_PD_res_src, bus.DFO_PD_res_tag, bus.DFO_PD_res_data, bus.DFO_PD_res_ofw);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int bad;
        int gseq[$];
        int gcyc[$];
        int rsrc[$];
        logic [31:0] rdat[$];

        set_req(0, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0);
        bus.CFI_PC_res_rdy = 1'b1;

        // Reset: clear overrides a valid request
        @(negedge clk); set_req(0, 1'b1, U_DIVU, 32'd1, 32'd1, 4'd1); #1;
        check("clr_rdy0", bus.CFO_PC_req0_rdy, 0);
        check("clr_ena", bus.CFO_PC_div_ena, 0);
        check("clr_div_clear", bus.CFO_PC_div_clear, 1);
        @(negedge clk); clear = 1'b0; set_req(0, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0); #1;
        check("rst_res_vld", bus.CFO_PC_res_vld, 0);
        check("rst_res_data", bus.DFO_PD_res_data, 0);
        check("rst_res_tag", bus.DFO_PD_res_tag, 0);
        check("rst_res_src", bus.DFO_PD_res_src, 0);
        check("rst_div_clear", bus.CFO_PC_div_clear, 0);
        $display("txn: reset done");

        // Single DIVU 100/7 from requester 0
        @(negedge clk); set_req(0, 1'b1, U_DIVU, 32'd100, 32'd7, 4'd3); #1;
        check("t1_rdy0", bus.CFO_PC_req0_rdy, 1);
        check("t1_rdy1", bus.CFO_PC_req1_rdy, 0);
        check("t1_ena", bus.CFO_PC_div_ena, 1);
        check("t1_uops", bus.DFO_PD_div_uops, U_DIVU);
        check("t1_rs", bus.DFO_PD_div_rs, 100);
        check("t1_rt", bus.DFO_PD_div_rt, 7);
        wait_res(2'b11, n);
        check("t1_lat", n, LAT + 1);
        check("t1_data", bus.DFO_PD_res_data, 14);
        check("t1_tag", bus.DFO_PD_res_tag, 3);
        check("t1_src", bus.DFO_PD_res_src, 0);
        check("t1_ofw", bus.DFO_PD_res_ofw, 0);
        @(negedge clk); #1;
        check("t1_drained", bus.CFO_PC_res_vld, 0);

        // Both requesters valid continuously, starting from a fresh pointer
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        @(negedge clk);
        set_req(0, 1'b1, U_DIVU, 32'd40, 32'd4, 4'd1);
        set_req(1, 1'b1, U_DIVU, 32'd81, 32'd9, 4'd2);
        for (int c = 0; c < 300 && rdat.size() < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (gseq.size() >= 4) begin
                bus.CFI_PC_req0_vld = 1'b0;
                bus.CFI_PC_req1_vld = 1'b0;
            end
            #1;
            if (bus.CFO_PC_req0_rdy) begin gseq.push_back(0); gcyc.push_back(c); end
            if (bus.CFO_PC_req1_rdy) begin gseq.push_back(1); gcyc.push_back(c); end
            if (gseq.size() == 1 && c == gcyc[0] + 1) check("t2_ptr_view", bus.DFO_PD_div_rs, 81);
            if (bus.CFO_PC_res_vld) begin
                rsrc.push_back(int'(bus.DFO_PD_res_src));
                rdat.push_back(bus.DFO_PD_res_data);
                $display("result: src=%0d tag=%0d data=%h", bus.DFO_PD_res_src, bus.DFO_PD_res_tag, bus.DFO_PD_res_data);
            end
        end
        check("t2_n_grants", gseq.size(), 4);
        check("t2_n_results", rdat.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_grant%0d", i), (i < gseq.size()) ? gseq[i] : -1, i % 2);
            check($sformatf("t2_src%0d", i), (i < rsrc.size()) ? rsrc[i] : -1, i % 2);
            check($sformatf("t2_data%0d", i), (i < rdat.size()) ? rdat[i] : 32'hFFFF_FFFF, (i % 2) ? 9 : 10);
        end
        check("t2_period", (gcyc.size() > 1) ? gcyc[1] - gcyc[0] : -1, LAT + 1);

        // Result buffer full while a second op completes -> HOLD, no grants
        @(negedge clk);
        bus.CFI_PC_res_rdy = 1'b0;
        set_req(0, 1'b1, U_DIVU, 32'd7, 32'd7, 4'd4);
        set_req(1, 1'b1, U_DIVU, 32'd50, 32'd5, 4'd5);
        #1;
        check("t3_g0", bus.CFO_PC_req0_rdy, 1);
        wait_res(2'b01, n);
        check("t3_lat", n, LAT + 1);
        check("t3_data_a", bus.DFO_PD_res_data, 1);
        check("t3_g1", bus.CFO_PC_req1_rdy, 1);
        @(negedge clk);
        set_req(1, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0);
        set_req(0, 1'b1, U_DIVU, 32'd9, 32'd3, 4'd7);
        bad = 0;
        for (int c = 0; c < 45; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (bus.CFO_PC_req0_rdy || bus.CFO_PC_req1_rdy || !bus.CFO_PC_res_vld ||
                bus.DFO_PD_res_data != 32'd1) bad++;
        end
        check("t3_hold_stall", bad, 0);
        @(negedge clk); bus.CFI_PC_res_rdy = 1'b1; #1;
        check("t3_old_data", bus.DFO_PD_res_data, 1);
        check("t3_no_grant_hold", bus.CFO_PC_req0_rdy, 0);
        @(negedge clk); #1;
        check("t3_vld_b", bus.CFO_PC_res_vld, 1);
        check("t3_data_b", bus.DFO_PD_res_data, 10);
        check("t3_src_b", bus.DFO_PD_res_src, 1);
        check("t3_tag_b", bus.DFO_PD_res_tag, 5);
        check("t3_regrant", bus.CFO_PC_req0_rdy, 1);
        wait_res(2'b01, n);
        check("t3_lat_c", n, LAT + 1);
        check("t3_data_c", bus.DFO_PD_res_data, 3);
        check("t3_tag_c", bus.DFO_PD_res_tag, 7);

        // Clear while the divider is busy (cnt = 20)
        @(negedge clk); set_req(0, 1'b1, U_DIVU, 32'd100, 32'd7, 4'd8); #1;
        check("t4_lone_wins", bus.CFO_PC_req0_rdy, 1);
        @(negedge clk); bus.CFI_PC_req0_vld = 1'b0;
        repeat (19) @(negedge clk);
        clear = 1'b1; #1;
        check("t4_div_clear", bus.CFO_PC_div_clear, 1);
        @(negedge clk); clear = 1'b0;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk); #1;
            if (bus.CFO_PC_res_vld || bus.CFO_PC_div_ena) bad++;
        end
        check("t4_no_result", bad, 0);
        @(negedge clk);
        set_req(0, 1'b1, U_DIVU, 32'd9, 32'd3, 4'd2);
        set_req(1, 1'b1, U_DIVU, 32'd8, 32'd2, 4'd3);
        #1;
        check("t4_ptr_reset", bus.CFO_PC_req0_rdy, 1);
        wait_res(2'b11, n);
        check("t4_lat", n, LAT + 1);
        check("t4_data", bus.DFO_PD_res_data, 3);
        check("t4_src", bus.DFO_PD_res_src, 0);

        // Signed overflow reported through the result
        @(negedge clk); set_req(1, 1'b1, U_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'd9); #1;
        check("t5_rdy1", bus.CFO_PC_req1_rdy, 1);
        wait_res(2'b10, n);
        check("t5_data", bus.DFO_PD_res_data, 32'h8000_0000);
        check("t5_ofw", bus.DFO_PD_res_ofw, 1);
        check("t5_src", bus.DFO_PD_res_src, 1);

        // Divide by zero
`ifdef DIV_SCHED_DZ_FAST_EN
        @(negedge clk); bus.CFI_PC_res_rdy = 1'b0; set_req(0, 1'b1, U_DIVU, 32'd5, 32'd0, 4'd1); #1;
        check("t6_dz_rdy", bus.CFO_PC_req0_rdy, 1);
        check("t6_dz_ena", bus.CFO_PC_div_ena, 0);
        @(negedge clk); set_req(0, 1'b1, U_REMU, 32'd5, 32'd0, 4'd2); #1;
        check("t6_dz_vld", bus.CFO_PC_res_vld, 1);
        check("t6_dz_data", bus.DFO_PD_res_data, 32'hFFFF_FFFF);
        check("t6_dz_ofw", bus.DFO_PD_res_ofw, 0);
        check("t6_dz_block", bus.CFO_PC_req0_rdy, 0);
        @(negedge clk); bus.CFI_PC_res_rdy = 1'b1; #1;
        check("t6_dz_drain_rdy", bus.CFO_PC_req0_rdy, 1);
        check("t6_dz_ena2", bus.CFO_PC_div_ena, 0);
        @(negedge clk); bus.CFI_PC_req0_vld = 1'b0; #1;
        check("t6_rem_vld", bus.CFO_PC_res_vld, 1);
        check("t6_rem_data", bus.DFO_PD_res_data, 5);
        check("t6_rem_tag", bus.DFO_PD_res_tag, 2);
        $display("txn: zero-divisor shortcut done");
`else
        @(negedge clk); set_req(0, 1'b1, U_DIVU, 32'd5, 32'd0, 4'd1); #1;
        check("t6_rdy", bus.CFO_PC_req0_rdy, 1);
        check("t6_ena", bus.CFO_PC_div_ena, 1);
        wait_res(2'b01, n);
        check("t6_lat", n, LAT + 1);
        check("t6_data", bus.DFO_PD_res_data, 32'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
